// File: rtl/jk_lab_pkg.sv
// rtl/jk_lab_pkg.sv - JK cell excitation encodings and next-state excitation helper
package jk_lab_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Returns {J,K}; never JK_TOGGLE, so each cell only holds, sets or resets.
  function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
    return {nxt & ~q, q & ~nxt};
  endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// rtl/jk_ff_sync.sv - single-bit JK flip-flop with synchronous active-high clear
module jk_ff_sync
  import jk_lab_pkg::*;
(
  input  logic cp,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  always_ff @(posedge cp) begin
    if (clr) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:  q <= q;
        JK_RESET: q <= 1'b0;
        JK_SET:   q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - up/down modulo-N counter built from JK cells with load clamp and wrap pulse
module jk_mod_counter
  import jk_lab_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             cp,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || WIDTH > 8 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $fatal(1, "jk_mod_counter: WIDTH must be 2..8 and MODULUS 2..2**WIDTH");
  end

  logic             at_end;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;

  always_comb begin
    at_end = up ? (q == LAST) : (q == '0);
    tc     = en & ~ld & ~clr & at_end;
    nxt    = q;
    if (clr) begin
      nxt = '0;
    end else if (ld) begin
      nxt = (32'(d) < MODULUS) ? d : LAST;
    end else if (en) begin
      if (at_end) nxt = up ? '0 : LAST;
      else        nxt = up ? q + WIDTH'(1) : q - WIDTH'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign {jk_j[i], jk_k[i]} = jk_excite(q[i], nxt[i]);

    jk_ff_sync u_cell (
      .cp  (cp),
      .clr (clr),
      .j   (jk_j[i]),
      .k   (jk_k[i]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

  // A wrapping edge is exactly an edge sampled while tc is high.
  always_ff @(posedge cp) begin
    if (clr) wrap <= 1'b0;
    else     wrap <= tc;
  end

endmodule
